// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO write arbiter.
// Holds the arbiter state enum, default sizes and the rotate pick.
package fifo_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MAX_BURST  = 16;
  localparam int PICK_MAX       = 8;

  // First set bit of valid at or above ptr, wrapping at n.
  // Returns ptr when nothing is valid.
  function automatic int unsigned rr_pick(
    input logic [PICK_MAX-1:0] valid,
    input int unsigned         ptr,
    input int unsigned         n
  );
    int unsigned r;
    int unsigned j;
    bit          found;
    r     = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < PICK_MAX; i++) begin
      j = (ptr + i) % n;
      if (i < n && !found && valid[j[2:0]]) begin
        r     = j;
        found = 1'b1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_if.sv
// Write side of a FIFO: enable, data and full flag.
// The arbiter is the master; the FIFO is the slave.
interface fifo_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  wen;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  full;

  modport master (
    output wen,
    output wdata,
    input  full
  );

  modport slave (
    input  wen,
    input  wdata,
    output full
  );
endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker.
// Rotates priority so the search starts at i_ptr.
module rr_picker
  import fifo_arb_pkg::*;
#(
  parameter  int N  = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  i_valid,
  input  logic [PW-1:0] i_ptr,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  assign o_idx = PW'(rr_pick(PICK_MAX'(i_valid),
                             32'(i_ptr), N));
  assign o_any = |i_valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a FIFO, with burst lock.
// Define FIFO_ARB_STATS_EN to add per-requester beat counters.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NUM_REQ    = DEF_NUM_REQ,
  parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter  int MAX_BURST  = DEF_MAX_BURST,
  localparam int PW         = $clog2(NUM_REQ),
  localparam int CW         = $clog2(MAX_BURST + 1)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ-1:0]                  req_lock,
  output logic [NUM_REQ-1:0]                  req_ready,
  fifo_if.master                              ifp_ff,
  output logic [PW-1:0]                       grant_id
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ-1:0][15:0]            beat_cnt
`endif
);

  localparam bit            LOCK_OK = (MAX_BURST > 1);
  localparam logic [PW-1:0] LAST    = PW'(NUM_REQ - 1);
  localparam logic [CW-1:0] CAP     = CW'(MAX_BURST);

  arb_state_t            r_state;
  arb_state_t            w_state_nx;
  logic [PW-1:0]         r_rr_ptr;
  logic [PW-1:0]         w_rr_ptr_nx;
  logic [PW-1:0]         r_owner;
  logic [PW-1:0]         w_owner_nx;
  logic [CW-1:0]         r_burst_cnt;
  logic [CW-1:0]         w_burst_nx;
  logic [CW-1:0]         w_burst_inc;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [PW-1:0]         w_pick;
  logic                  w_pick_any;
  logic [PW-1:0]         w_win;
  logic [PW-1:0]         w_win_nxt;
  logic                  w_win_vld;
  logic                  w_acc;
  logic [NUM_REQ-1:0]    w_ready;

  rr_picker #(
    .N (NUM_REQ)
  ) u_pick (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_idx   (w_pick),
    .o_any   (w_pick_any)
  );

  // Winner selection, accept, next-state and per-beat outputs.
  always_comb begin
    w_state_nx  = r_state;
    w_rr_ptr_nx = r_rr_ptr;
    w_owner_nx  = r_owner;
    w_burst_nx  = r_burst_cnt;
    w_ready     = '0;
    w_burst_inc = r_burst_cnt + 1'b1;
    if (r_state == LOCKED) begin
      w_win     = r_owner;
      w_win_vld = req_valid[r_owner];
    end else begin
      w_win     = w_pick;
      w_win_vld = w_pick_any;
    end
    w_win_nxt = (w_win == LAST) ? '0 : w_win + 1'b1;
    w_acc     = !rst && w_win_vld && !ifp_ff.full;
    if (w_acc) w_ready[w_win] = 1'b1;
    unique case (r_state)
      IDLE: begin
        if (w_acc) begin
          if (LOCK_OK && req_lock[w_win]) begin
            w_state_nx = LOCKED;
            w_owner_nx = w_win;
            w_burst_nx = CW'(1);
          end else begin
            w_rr_ptr_nx = w_win_nxt;
          end
        end
      end
      LOCKED: begin
        if (w_acc) begin
          w_burst_nx = w_burst_inc;
          if (w_burst_inc == CAP ||
              !req_lock[r_owner]) begin
            w_state_nx  = IDLE;
            w_rr_ptr_nx = w_win_nxt;
            w_burst_nx  = '0;
          end
        end else if (!ifp_ff.full &&
                     !req_valid[r_owner] &&
                     !req_lock[r_owner]) begin
          w_state_nx  = IDLE;
          w_rr_ptr_nx = w_win_nxt;
          w_burst_nx  = '0;
        end
      end
    endcase
  end

  assign req_ready    = w_ready;
  assign grant_id     = rst ? '0 : w_win;
  assign ifp_ff.wen   = w_acc;
  assign ifp_ff.wdata = rst   ? '0 :
                        w_acc ? req_data[w_win] :
                                r_wdata;

  // State, pointer, burst count and last written data.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_wdata     <= '0;
    end else begin
      r_state     <= w_state_nx;
      r_rr_ptr    <= w_rr_ptr_nx;
      r_owner     <= w_owner_nx;
      r_burst_cnt <= w_burst_nx;
      if (w_acc) r_wdata <= req_data[w_win];
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [NUM_REQ-1:0][15:0] r_beat_cnt;

  // Saturating per-requester accepted-beat counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_beat_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_ready[i] && r_beat_cnt[i] != 16'hFFFF)
          r_beat_cnt[i] <= r_beat_cnt[i] + 16'd1;
      end
    end
  end

  assign beat_cnt = r_beat_cnt;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter.
// Covers reset, fairness, backpressure, burst cap, bubble, stats.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic                 clk;
  logic                 rst;
  logic [N-1:0]         req_valid;
  logic [N-1:0]         req_lock;
  logic [N-1:0]         req_ready;
  logic [N-1:0][DW-1:0] req_data;
  logic [1:0]           grant_id;
`ifdef FIFO_ARB_STATS_EN
  logic [N-1:0][15:0]   beat_cnt;
`endif

  int checks;
  int failures;

  fifo_if #(.DATA_WIDTH(DW)) ff ();

  fifo_wr_arbiter #(
    .NUM_REQ    (N),
    .DATA_WIDTH (DW),
    .MAX_BURST  (MB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_lock  (req_lock),
    .req_ready (req_ready),
    .ifp_ff    (ff),
    .grant_id  (grant_id)
`ifdef FIFO_ARB_STATS_EN
    ,
    .beat_cnt  (beat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_rst();
    rst = 1'b1;
    req_valid = '0;
    req_lock = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    req_lock = '1;
    ff.full = 1'b0;
    step();
    step();
    settle();
    checks++;
    if (ff.wen !== 1'b0) begin
      failures++;
      $display("FAIL reset_wen got=%0b exp=0", ff.wen);
    end
    checks++;
    if (req_ready !== 4'b0000) begin
      failures++;
      $display("FAIL reset_ready got=%b exp=0000", req_ready);
    end
    checks++;
    if (ff.wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_wdata got=%h exp=0", ff.wdata);
    end
    checks++;
    if (grant_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_grant got=%0d exp=0", grant_id);
    end
    step();
    rst = 1'b0;
    req_valid = '0;
    req_lock = '0;
  endtask

  task automatic test_fairness();
    logic [1:0] g;
    req_valid = 4'b1111;
    req_lock = '0;
    ff.full = 1'b0;
    for (int i = 0; i < 8; i++) begin
      g = 2'(i % 4);
      settle();
      checks++;
      if (grant_id !== g) begin
        failures++;
        $display("FAIL fair_grant[%0d] got=%0d exp=%0d",
                 i, grant_id, g);
      end
      checks++;
      if (ff.wen !== 1'b1) begin
        failures++;
        $display("FAIL fair_wen[%0d] got=%0b exp=1", i, ff.wen);
      end
      checks++;
      if (req_ready !== (4'b0001 << g)) begin
        failures++;
        $display("FAIL fair_ready[%0d] got=%b exp=%b",
                 i, req_ready, 4'b0001 << g);
      end
      checks++;
      if (ff.wdata !== (32'hCAFE_0000 + 32'(g))) begin
        failures++;
        $display("FAIL fair_wdata[%0d] got=%h exp=%h",
                 i, ff.wdata, 32'hCAFE_0000 + 32'(g));
      end
      step();
    end
  endtask

  task automatic test_backpressure();
    req_valid = 4'b0110;
    ff.full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      checks++;
      if (ff.wen !== 1'b0) begin
        failures++;
        $display("FAIL bp_wen[%0d] got=%0b exp=0", i, ff.wen);
      end
      checks++;
      if (req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bp_ready[%0d] got=%b exp=0000",
                 i, req_ready);
      end
      checks++;
      if (ff.wdata !== 32'hCAFE_0003) begin
        failures++;
        $display("FAIL bp_wdata_hold[%0d] got=%h exp=cafe0003",
                 i, ff.wdata);
      end
      step();
    end
    ff.full = 1'b0;
    settle();
    checks++;
    if (req_ready !== 4'b0010 || grant_id !== 2'd1) begin
      failures++;
      $display("FAIL bp_first got=%b/%0d exp=0010/1",
               req_ready, grant_id);
    end
    step();
    settle();
    checks++;
    if (req_ready !== 4'b0100 || grant_id !== 2'd2) begin
      failures++;
      $display("FAIL bp_second got=%b/%0d exp=0100/2",
               req_ready, grant_id);
    end
    step();
    req_valid = '0;
  endtask

  task automatic test_burst_cap();
    int exp_g [6];
    exp_g = '{0, 0, 0, 0, 3, 0};
    do_rst();
    req_valid = 4'b1001;
    req_lock = 4'b0001;
    for (int i = 0; i < 6; i++) begin
      settle();
      checks++;
      if (grant_id !== 2'(exp_g[i])) begin
        failures++;
        $display("FAIL burst_grant[%0d] got=%0d exp=%0d",
                 i, grant_id, exp_g[i]);
      end
      checks++;
      if (req_ready !== (4'b0001 << exp_g[i])) begin
        failures++;
        $display("FAIL burst_ready[%0d] got=%b exp=%b",
                 i, req_ready, 4'b0001 << exp_g[i]);
      end
      step();
    end
    req_valid = '0;
    req_lock = '0;
    settle();
    checks++;
    if (ff.wen !== 1'b0) begin
      failures++;
      $display("FAIL burst_release_wen got=%0b exp=0", ff.wen);
    end
    step();
  endtask

  task automatic test_lock_bubble();
    do_rst();
    req_valid = 4'b0100;
    req_lock = 4'b0100;
    settle();
    checks++;
    if (req_ready !== 4'b0100 || grant_id !== 2'd2) begin
      failures++;
      $display("FAIL bub_start got=%b/%0d exp=0100/2",
               req_ready, grant_id);
    end
    step();
    req_valid = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (ff.wen !== 1'b0 || req_ready !== 4'b0000) begin
        failures++;
        $display("FAIL bub_hole[%0d] got=%0b/%b exp=0/0000",
                 i, ff.wen, req_ready);
      end
      checks++;
      if (grant_id !== 2'd2) begin
        failures++;
        $display("FAIL bub_owner[%0d] got=%0d exp=2",
                 i, grant_id);
      end
      step();
    end
    req_valid = 4'b0101;
    settle();
    checks++;
    if (req_ready !== 4'b0100 ||
        ff.wdata !== 32'hCAFE_0002) begin
      failures++;
      $display("FAIL bub_resume got=%b/%h exp=0100/cafe0002",
               req_ready, ff.wdata);
    end
    step();
    req_lock = 4'b0000;
    settle();
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL bub_last got=%b exp=0100", req_ready);
    end
    step();
    settle();
    checks++;
    if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL bub_after got=%b/%0d exp=0001/0",
               req_ready, grant_id);
    end
    step();
  endtask

  task automatic test_reset_mid_burst();
    req_valid = 4'b0010;
    req_lock = 4'b0010;
    for (int i = 0; i < 2; i++) begin
      settle();
      checks++;
      if (req_ready !== 4'b0010 || grant_id !== 2'd1) begin
        failures++;
        $display("FAIL rmb_lock[%0d] got=%b/%0d exp=0010/1",
                 i, req_ready, grant_id);
      end
      step();
    end
    rst = 1'b1;
    req_valid = 4'b1111;
    settle();
    checks++;
    if (ff.wen !== 1'b0 || req_ready !== 4'b0000 ||
        grant_id !== 2'd0) begin
      failures++;
      $display("FAIL rmb_rst got=%0b/%b/%0d exp=0/0000/0",
               ff.wen, req_ready, grant_id);
    end
    step();
    rst = 1'b0;
    req_lock = '0;
    settle();
    checks++;
    if (req_ready !== 4'b0001 || grant_id !== 2'd0) begin
      failures++;
      $display("FAIL rmb_after got=%b/%0d exp=0001/0",
               req_ready, grant_id);
    end
    step();
    req_valid = '0;
  endtask

`ifdef FIFO_ARB_STATS_EN
  task automatic test_stats();
    do_rst();
    req_valid = 4'b0001;
    req_lock = '0;
    repeat (70000) step();
    req_valid = '0;
    settle();
    checks++;
    if (beat_cnt[0] !== 16'hFFFF) begin
      failures++;
      $display("FAIL stats_sat got=%h exp=ffff", beat_cnt[0]);
    end
    for (int i = 1; i < N; i++) begin
      checks++;
      if (beat_cnt[i] !== 16'h0) begin
        failures++;
        $display("FAIL stats_other[%0d] got=%h exp=0",
                 i, beat_cnt[i]);
      end
    end
    step();
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req_valid = '0;
    req_lock = '0;
    ff.full = 1'b0;
    for (int i = 0; i < N; i++)
      req_data[i] = 32'hCAFE_0000 + 32'(i);
    test_reset();
    test_fairness();
    test_backpressure();
    test_burst_cap();
    test_lock_bubble();
    test_reset_mid_burst();
`ifdef FIFO_ARB_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4, SHALL set the number of write requesters (2..8).
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the per-requester write data width and SHALL equal the FIFO wdata width.
REQ-003 Parameter MAX_BURST, default 16, SHALL set the maximum beats per locked grant (1..256).
REQ-004 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-006 Port req_valid  input  NUM_REQ  SHALL carry the per-requester write request.
REQ-007 Port req_data  input  NUM_REQ x DATA_WIDTH  SHALL carry the per-requester write data.
REQ-008 Port req_lock  input  NUM_REQ  SHALL carry the per-requester burst-hold request.
REQ-009 Port req_ready  output  NUM_REQ  SHALL indicate that the requester's beat is accepted this cycle.
REQ-010 Port ifp_ff  fifo_if.master  -  SHALL drive wen and wdata and sample full.
REQ-011 Port grant_id  output  $clog2(NUM_REQ)  SHALL give the index of the current winner (valid when any req_valid).

Function
REQ-012 Arbitration: round-robin from registered pointer rr_ptr; winner = first i with req_valid[i], searching from rr_ptr upward with wrap.
REQ-013 Winner is combinational (zero-cycle arbitration latency); a beat is accepted when winner valid and !full.
REQ-014 On accept: req_ready[winner]=1, wen=1, wdata=req_data[winner], all in the same cycle; at most one req_ready bit high per cycle.
REQ-015 When full=1: wen=0, all req_ready=0, and rr_ptr, state and burst count SHALL hold.
REQ-016 States: IDLE, LOCKED.
REQ-017 IDLE: on accept with req_lock[winner]=1 and MAX_BURST>1, go to LOCKED, owner<=winner, burst_cnt<=1; on accept without lock, rr_ptr<=winner+1 (mod NUM_REQ).
REQ-018 LOCKED: only the owner is eligible, and other requesters see req_ready=0.
REQ-019 LOCKED: on accept, burst_cnt increments.
REQ-020 LOCKED exit to IDLE with rr_ptr<=owner+1 when: an accept brings burst_cnt to MAX_BURST, or an accept occurs with req_lock[owner]=0, or owner req_valid=0 and req_lock[owner]=0 (release without a beat).
REQ-021 LOCKED with owner req_valid=0 and lock=1 SHALL hold the grant with wen=0 (bubble allowed).
REQ-022 No requester valid: wen=0, state and rr_ptr unchanged.
REQ-023 wdata SHALL hold its previous value when wen=0.

Reset
REQ-024 While rst=1: wen=0, req_ready=0, wdata=0, grant_id=0, state=IDLE, rr_ptr=0, burst_cnt=0, and statistics counters 0.
REQ-025 Reset asserted mid-burst SHALL abandon the lock; no beat is accepted in the rst cycle.

Configuration
REQ-026 Macro FIFO_ARB_STATS_EN defined: add output beat_cnt (NUM_REQ x 16), a per-requester saturating count of accepted beats (saturates at 16'hFFFF, cleared by rst).
REQ-027 FIFO_ARB_STATS_EN undefined: no beat_cnt port and no counter logic; all other behaviour is identical.

Structure
REQ-028 Package fifo_arb_pkg SHALL hold the state enum arb_state_t {IDLE, LOCKED}, the default NUM_REQ/DATA_WIDTH/MAX_BURST constants, and the function rr_pick(valid, ptr).
REQ-029 One sub-module, rr_picker (combinational priority rotate), is natural; the FSM, counters and FIFO drive stay in fifo_wr_arbiter.

Verification
REQ-030 Fairness: all 4 req_valid held high, no lock, full=0 for 8 cycles -> grants in order 0,1,2,3,0,1,2,3 with wen=1 every cycle.
REQ-031 Backpressure: full=1 for 3 cycles with requesters 1 and 2 valid -> wen=0 and req_ready=0 for 3 cycles; then grant goes to 1, then to 2.
REQ-032 Burst cap: MAX_BURST=4, requester 0 lock=1 and valid for 10 cycles, requester 3 valid -> 4 beats from 0, then 3 granted, then 0 again.
REQ-033 Lock bubble: owner 2 locked, valid drops for 2 cycles with lock=1 -> wen=0 for 2 cycles, requester 0 is not granted, and the burst resumes from 2.
REQ-034 Reset mid-burst: rst pulsed during a locked burst from requester 1 -> wen=0 in the rst cycle; afterwards rr_ptr=0 and requester 0 wins if valid.
REQ-035 With FIFO_ARB_STATS_EN defined: 70000 accepts by requester 0 -> beat_cnt[0]=16'hFFFF and other counters unchanged.
